mips_alu_md: RTL and testbench

Parametrised, registered execute-stage ALU for the MIPS pipeline. It adds to the basic logic/arith/compare/pass operations an iterative signed/unsigned multiply and divide unit with architectural HI/LO registers and a valid/ready issue handshake. The EX stage stalls on `in_ready` while a multiply or divide is in flight. Single-cycle operations keep their established 3-bit encodings in the low bits of a 4-bit opcode, so existing decode logic extends with a leading 0.

---
 rtl/mips_alu_pkg.sv | 36 +++
 rtl/mips_muldiv_seq.sv | 87 ++++++++
 rtl/mips_alu_md.sv | 216 +++++++++++++++++++++
 tb/tb_mips_alu_md.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: shared definitions for the MIPS execute-stage ALU with
// iterative multiply/divide.
//   DEFAULT_WIDTH : default datapath width.
//   alu_op_t      : 4-bit operation codes. Single-cycle codes keep their
//                   legacy 3-bit encoding behind a leading 0.
//   state_t       : issue FSM states.
//   is_multi      : true for MULT/MULTU/DIV/DIVU (opcode 10xx).
package mips_alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_PASSA = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLTU  = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_MFHI  = 4'b1100,
        OP_MFLO  = 4'b1101
    } alu_op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic is_multi(input logic [3:0] op_code);
        return (op_code[3:2] == 2'b10);
    endfunction

endpackage

// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq: unsigned iterative engine, one step per cycle.
//   clk, rst_n : clock, synchronous active-low reset.
//   start      : load magnitudes and mode, clear the step counter.
//   step       : perform one step this cycle.
//   mode_div   : 0 = shift-add multiply, 1 = restoring divide.
//   a_mag/b_mag: unsigned operands (multiplicand/multiplier, dividend/divisor).
//   res        : accumulator value after the current step; after the final
//                step it holds {product} or {remainder, quotient}.
//   done       : the step running this cycle is the final one.
module mips_muldiv_seq
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 step,
    input  logic                 mode_div,
    input  logic [WIDTH-1:0]     a_mag,
    input  logic [WIDTH-1:0]     b_mag,
    output logic [2*WIDTH-1:0]   res,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};

    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] acc_nxt_s;
    logic [WIDTH-1:0]   b_r;
    logic [CW-1:0]      cnt_r;
    logic               div_r;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH:0]     diff_s;

    // One multiply or divide step on the accumulator
    always_comb begin
        // Multiply: {hi,lo} holds partial product and remaining multiplier bits;
        // add B into hi when the current multiplier bit is set, then shift right.
        sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                + (acc_r[0] ? {1'b0, b_r} : {(WIDTH+1){1'b0}});
        // Divide: {rem,quo}; bring the next dividend bit into the remainder.
        // trial < 2*B always, so the MSB of diff_s is a clean borrow flag.
        trial_s = acc_r[2*WIDTH-1:WIDTH-1];
        diff_s  = trial_s - {1'b0, b_r};
        if (div_r) begin
            if (!diff_s[WIDTH]) begin
                acc_nxt_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt_s = {sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Result of the step running now and final-step indication
    always_comb begin
        res  = acc_nxt_s;
        done = step && (cnt_r == LAST_CNT);
    end

    // Engine registers: load on start, advance on step
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {(2*WIDTH){1'b0}};
            b_r   <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
            div_r <= 1'b0;
        end else if (start) begin
            acc_r <= {{WIDTH{1'b0}}, a_mag};
            b_r   <= b_mag;
            cnt_r <= {CW{1'b0}};
            div_r <= mode_div;
        end else if (step) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_r + ONE_CNT;
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/mips_alu_md.sv
// mips_alu_md: registered MIPS execute-stage ALU with iterative signed/unsigned
// multiply/divide and architectural HI/LO.
//   clk, rst_n  : clock, synchronous active-low reset.
//   in_valid    : an operation is presented on op/operand1/operand2.
//   in_ready    : operation accepted this cycle (low while busy or in reset).
//   op          : 4-bit operation code (alu_op_t).
//   operand1/2  : A and B operands.
//   flush       : abort an in-flight multiply/divide (no effect when idle).
//   out_valid   : one-cycle pulse, result valid.
//   result      : registered result (new LO for multiply/divide).
//   div_by_zero : with out_valid, the completed divide had B == 0.
module mips_alu_md
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam logic [WIDTH-1:0]   ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W = {{(2*WIDTH-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_nxt_s;
    logic               start_s;
    logic               single_s;
    logic               commit_s;
    logic               step_s;
    logic               eng_done_s;
    logic [2*WIDTH-1:0] eng_res_s;

    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   result_r;
    logic               out_valid_r;
    logic               div_by_zero_r;

    // Context of the in-flight multiply/divide
    logic               div_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic               dbz_pend_r;
    logic [WIDTH-1:0]   a_r;

    logic               sgn_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH-1:0]   alu_s;
    logic [WIDTH-1:0]   new_hi_s;
    logic [WIDTH-1:0]   new_lo_s;
    logic [2*WIDTH-1:0] prod_s;

    // Ready only when idle and out of reset
    always_comb begin
        in_ready = rst_n && (state_r == ST_IDLE);
    end

    // Issue FSM: next state and per-cycle control strobes
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        single_s    = 1'b0;
        commit_s    = 1'b0;
        step_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid && is_multi(op)) begin
                    state_nxt_s = ST_BUSY;
                    start_s     = 1'b1;
                end else if (in_valid) begin
                    state_nxt_s = ST_IDLE;
                    single_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                step_s = !flush;
                if (flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (eng_done_s) begin
                    state_nxt_s = ST_IDLE;
                    commit_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_BUSY;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Operand signs and magnitudes; odd multi-cycle codes are unsigned
    always_comb begin
        sgn_s   = !op[0];
        a_neg_s = sgn_s && operand1[WIDTH-1];
        b_neg_s = sgn_s && operand2[WIDTH-1];
        a_mag_s = a_neg_s ? (~operand1 + ONE_W) : operand1;
        b_mag_s = b_neg_s ? (~operand2 + ONE_W) : operand2;
    end

    // Single-cycle operation results
    always_comb begin
        case (op)
            OP_AND:   alu_s = operand1 & operand2;
            OP_OR:    alu_s = operand1 | operand2;
            OP_ADD:   alu_s = operand1 + operand2;
            OP_SUB:   alu_s = operand1 - operand2;
            OP_SLTU:  alu_s = {{(WIDTH-1){1'b0}}, (operand1 < operand2)};
            OP_PASSA: alu_s = operand1;
            OP_MFHI:  alu_s = hi_r;
            OP_MFLO:  alu_s = lo_r;
            default:  alu_s = {WIDTH{1'b0}};
        endcase
    end

    // Sign restoration and special cases for the completing operation.
    // Most-negative / -1 needs no special path: the magnitude quotient is
    // 2^(WIDTH-1), which already reads back as the most-negative value.
    always_comb begin
        prod_s = neg_q_r ? (~eng_res_s + ONE_2W) : eng_res_s;
        if (div_r) begin
            if (dbz_pend_r) begin
                new_lo_s = {WIDTH{1'b1}};
                new_hi_s = a_r;
            end else begin
                new_lo_s = neg_q_r ? (~eng_res_s[WIDTH-1:0] + ONE_W)
                                   : eng_res_s[WIDTH-1:0];
                new_hi_s = neg_r_r ? (~eng_res_s[2*WIDTH-1:WIDTH] + ONE_W)
                                   : eng_res_s[2*WIDTH-1:WIDTH];
            end
        end else begin
            new_lo_s = prod_s[WIDTH-1:0];
            new_hi_s = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    mips_muldiv_seq #(
        .WIDTH    (WIDTH)
    ) u_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_s),
        .step     (step_s),
        .mode_div (op[1]),
        .a_mag    (a_mag_s),
        .b_mag    (b_mag_s),
        .res      (eng_res_s),
        .done     (eng_done_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // HI/LO, result registers and in-flight operation context
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_r          <= {WIDTH{1'b0}};
            lo_r          <= {WIDTH{1'b0}};
            result_r      <= {WIDTH{1'b0}};
            out_valid_r   <= 1'b0;
            div_by_zero_r <= 1'b0;
            div_r         <= 1'b0;
            neg_q_r       <= 1'b0;
            neg_r_r       <= 1'b0;
            dbz_pend_r    <= 1'b0;
            a_r           <= {WIDTH{1'b0}};
        end else begin
            out_valid_r <= 1'b0;
            if (start_s) begin
                div_r      <= op[1];
                neg_q_r    <= a_neg_s ^ b_neg_s;
                neg_r_r    <= a_neg_s;
                dbz_pend_r <= op[1] && (operand2 == {WIDTH{1'b0}});
                a_r        <= operand1;
            end else if (single_s) begin
                out_valid_r   <= 1'b1;
                result_r      <= alu_s;
                div_by_zero_r <= 1'b0;
            end else if (commit_s) begin
                hi_r          <= new_hi_s;
                lo_r          <= new_lo_s;
                result_r      <= new_lo_s;
                out_valid_r   <= 1'b1;
                div_by_zero_r <= dbz_pend_r;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end
    end

    assign out_valid   = out_valid_r;
    assign result      = result_r;
    assign div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_mips_alu_md.sv
// tb_mips_alu_md: directed plus randomized self-checking bench for mips_alu_md
// (WIDTH = 32) against an arithmetic reference model of HI/LO and results.
module tb_mips_alu_md;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         flush = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] operand1 = '0;
    logic [W-1:0] operand2 = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         div_by_zero;

    int           n_cmp = 0;
    int           n_bad = 0;
    logic [W-1:0] hi_m = '0;
    logic [W-1:0] lo_m = '0;

    always #5 clk = ~clk;

    mips_alu_md #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .operand1    (operand1),
        .operand2    (operand2),
        .flush       (flush),
        .out_valid   (out_valid),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: result and div-by-zero flag, updates hi_m/lo_m.
    task automatic ref_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic dz);
        longint     sa, sb, q, rm;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        case (o)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0110: r = a - b;
            4'b0111: r = (a < b) ? 32'd1 : 32'd0;
            4'b0101: r = a;
            4'b1100: r = hi_m;
            4'b1101: r = lo_m;
            4'b1000: begin
                p = sa * sb;
                hi_m = p[63:32]; lo_m = p[31:0]; r = lo_m;
            end
            4'b1001: begin
                p = {32'd0, a} * {32'd0, b};
                hi_m = p[63:32]; lo_m = p[31:0]; r = lo_m;
            end
            4'b1010, 4'b1011: begin
                if (b == 32'd0) begin
                    lo_m = 32'hFFFF_FFFF; hi_m = a; dz = 1'b1;
                end else if (o == 4'b1010) begin
                    q = sa / sb; rm = sa % sb;
                    lo_m = q[31:0]; hi_m = rm[31:0];
                end else begin
                    lo_m = a / b; hi_m = a % b;
                end
                r = lo_m;
            end
            default: r = 32'd0;
        endcase
    endtask

    task automatic issue_single(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         dz;
        check("ready_before_single", {63'd0, in_ready}, 64'd1);
        op = o; operand1 = a; operand2 = b; in_valid = 1'b1;
        ref_op(o, a, b, r, dz);
        tick();
        in_valid = 1'b0;
        check($sformatf("single_valid_op%0h", o), {63'd0, out_valid}, 64'd1);
        check($sformatf("single_result_op%0h", o), {32'd0, result}, {32'd0, r});
        check("single_dbz", {63'd0, div_by_zero}, 64'd0);
    endtask

    task automatic issue_multi(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input int flush_at);
        logic [W-1:0] r;
        logic         dz;
        check("ready_before_multi", {63'd0, in_ready}, 64'd1);
        op = o; operand1 = a; operand2 = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= W; c++) begin
            check($sformatf("busy_ready_c%0d", c), {63'd0, in_ready}, 64'd0);
            check($sformatf("busy_valid_c%0d", c), {63'd0, out_valid}, 64'd0);
            if (c == flush_at) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
                check("flush_ready", {63'd0, in_ready}, 64'd1);
                check("flush_no_valid", {63'd0, out_valid}, 64'd0);
                return;
            end
            if (c < W) tick();
        end
        tick();
        ref_op(o, a, b, r, dz);
        check($sformatf("multi_valid_op%0h", o), {63'd0, out_valid}, 64'd1);
        check("multi_ready_done", {63'd0, in_ready}, 64'd1);
        check($sformatf("multi_lo_op%0h", o), {32'd0, result}, {32'd0, r});
        check($sformatf("multi_dbz_op%0h", o), {63'd0, div_by_zero}, {63'd0, dz});
        // MFHI issued in the completion cycle sees the new HI
        issue_single(4'b1100, 32'd0, 32'd0);
    endtask

    initial begin
        logic [3:0]   ro;
        logic [W-1:0] ra, rb;
        int           pulses;

        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        check("rst_ready", {63'd0, in_ready}, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_result", {32'd0, result}, 64'd0);
        check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", {63'd0, in_ready}, 64'd1);

        // Back-to-back single-cycle ops, undefined op
        issue_single(4'b0010, 32'hFFFF_FFFF, 32'd1);
        issue_single(4'b0111, 32'd3, 32'hFFFF_FFFF);
        issue_single(4'b0011, 32'h1234_5678, 32'h9ABC_DEF0);
        issue_single(4'b1101, 32'd0, 32'd0);

        // Multiply / divide directed cases
        issue_multi(4'b1000, 32'hFFFF_FFFE, 32'd3, 0);
        issue_multi(4'b1010, 32'hFFFF_FFF9, 32'd2, 0);
        issue_single(4'b1101, 32'd0, 32'd0);
        issue_multi(4'b1011, 32'd7, 32'd2, 0);
        issue_multi(4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue_multi(4'b1011, 32'd5, 32'd0, 0);
        issue_multi(4'b1010, 32'hFFFF_FFF0, 32'd0, 0);

        // Flush mid-multiply leaves HI/LO untouched
        issue_multi(4'b1001, 32'h10, 32'h10, 0);
        issue_multi(4'b1000, 32'd5, 32'd5, 10);
        issue_single(4'b1101, 32'd0, 32'd0);
        issue_single(4'b1100, 32'd0, 32'd0);

        // Flush while idle does not block an accept
        flush = 1'b1;
        issue_single(4'b0110, 32'd3, 32'd5);
        flush = 1'b0;

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb & 32'h0000_00FF;
            if (ro[3:2] == 2'b10) issue_multi(ro, ra, rb, 0);
            else issue_single(ro, ra, rb);
        end

        // Reset in the middle of a divide
        op = 4'b1010; operand1 = 32'd100; operand2 = 32'd7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        rst_n = 1'b0;
        tick();
        check("midrst_ready", {63'd0, in_ready}, 64'd0);
        check("midrst_valid", {63'd0, out_valid}, 64'd0);
        rst_n = 1'b1;
        hi_m = '0;
        lo_m = '0;
        tick();
        check("after_midrst_ready", {63'd0, in_ready}, 64'd1);
        pulses = 0;
        for (int c = 0; c < W + 4; c++) begin
            if (out_valid) pulses++;
            tick();
        end
        check("no_stray_valid", 64'(pulses), 64'd0);
        issue_single(4'b1100, 32'd0, 32'd0);
        issue_single(4'b1101, 32'd0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
